// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the external memory/IO bus between the execution unit (EU)
// and the prefetch unit (PF). EU has priority, and a starvation guard forces a PF grant
// after STARVE_LIMIT consecutive EU grants while PF waits. EU word accesses at odd
// addresses are split into two byte beats. Byte lanes are steered onto the bus here.
//
// Ports:
//   clk, reset_n                 clock and asynchronous active-low reset
//   eu_command/word/address      EU request (0 idle, 1 read, 2 write, 3 idle), held to eu_done
//   eu_data_out / eu_data_in     EU write data in, EU read data out (valid with eu_done)
//   eu_done                      1-cycle pulse when an EU access completes
//   pf_req/pf_address/pf_flush   prefetch word-read request, address, discard strobe
//   pf_data / pf_done            fetched word and its 1-cycle completion pulse
//   mem_command/address/byte_en  registered bus beat; address is always word aligned
//   mem_data_out / mem_data_in   lane-steered write data, raw read data
//   mem_ready                    bus completes the current beat this cycle
module bus_arbiter #(
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        eu_command,
    input  logic              eu_word,
    input  logic [ADDR_W-1:0] eu_address,
    input  logic [15:0]       eu_data_out,
    output logic [15:0]       eu_data_in,
    output logic              eu_done,
    input  logic              pf_req,
    input  logic [ADDR_W-1:0] pf_address,
    input  logic              pf_flush,
    output logic [15:0]       pf_data,
    output logic              pf_done,
    output logic [1:0]        mem_command,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_byte_en,
    output logic [15:0]       mem_data_out,
    input  logic [15:0]       mem_data_in,
    input  logic              mem_ready
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EU_B0 = 3'd1,
        S_EU_B1 = 3'd2,
        S_PF_RD = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                flush_q, flush_d;
    logic [7:0]          lo_byte_q, lo_byte_d;

    logic [1:0]        mem_command_d;
    logic [ADDR_W-1:0] mem_address_d;
    logic [1:0]        mem_byte_en_d;
    logic [15:0]       mem_data_out_d;
    logic [15:0]       eu_data_in_d;
    logic              eu_done_d;
    logic [15:0]       pf_data_d;
    logic              pf_done_d;

    // Request decode and arbitration (only meaningful in IDLE)
    logic              eu_cmd_valid;
    logic              starved;
    logic              eu_grant;
    logic              pf_grant;
    logic              eu_split;
    logic              eu_is_read;
    logic              flush_now;
    logic [ADDR_W-1:0] eu_word_addr;
    logic [ADDR_W-1:0] eu_next_word_addr;
    logic [1:0]        b0_byte_en;
    logic [15:0]       b0_data;
    logic [15:0]       b0_read_data;

    assign eu_cmd_valid = (eu_command == 2'd1) || (eu_command == 2'd2);
    assign eu_is_read   = (eu_command == 2'd1);
    assign starved      = pf_req && (starve_q == STARVE_W'(STARVE_LIMIT));
    assign eu_grant     = (state_q == S_IDLE) && eu_cmd_valid && !starved;
    assign pf_grant     = (state_q == S_IDLE) && !eu_grant && pf_req && !pf_flush;
    assign eu_split     = eu_word && eu_address[0];
    assign flush_now    = flush_q || pf_flush;

    assign eu_word_addr      = {eu_address[ADDR_W-1:1], 1'b0};
    // Second beat of a split word; wraps at the top of the address space
    assign eu_next_word_addr = {eu_address[ADDR_W-1:1] + (ADDR_W-1)'(1), 1'b0};

    // First-beat lane steering
    always_comb begin
        b0_byte_en   = 2'b11;
        b0_data      = eu_data_out;
        b0_read_data = mem_data_in;
        if (!eu_word || eu_address[0]) begin
            if (eu_address[0]) begin
                b0_byte_en   = 2'b10;
                b0_data      = {eu_data_out[7:0], 8'h00};
                b0_read_data = {8'h00, mem_data_in[15:8]};
            end else begin
                b0_byte_en   = 2'b01;
                b0_data      = {8'h00, eu_data_out[7:0]};
                b0_read_data = {8'h00, mem_data_in[7:0]};
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (eu_grant) begin
                    state_d = S_EU_B0;
                end else if (pf_grant) begin
                    state_d = S_PF_RD;
                end
            end
            S_EU_B0: begin
                if (mem_ready) begin
                    state_d = eu_split ? S_EU_B1 : S_DONE;
                end
            end
            // mem_command is 0 for the first EU_B1 cycle: the mandatory idle bus gap
            S_EU_B1: begin
                if ((mem_command != 2'd0) && mem_ready) begin
                    state_d = S_DONE;
                end
            end
            S_PF_RD: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of registered outputs and internal datapath state
    always_comb begin
        mem_command_d  = mem_command;
        mem_address_d  = mem_address;
        mem_byte_en_d  = mem_byte_en;
        mem_data_out_d = mem_data_out;
        eu_data_in_d   = eu_data_in;
        pf_data_d      = pf_data;
        eu_done_d      = 1'b0;
        pf_done_d      = 1'b0;
        lo_byte_d      = lo_byte_q;
        flush_d        = flush_q;
        starve_d       = starve_q;

        if (!pf_req) begin
            starve_d = '0;
        end else if (eu_grant) begin
            if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end else if (pf_grant) begin
            starve_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (eu_grant) begin
                    mem_command_d  = eu_command;
                    mem_address_d  = eu_word_addr;
                    mem_byte_en_d  = b0_byte_en;
                    mem_data_out_d = b0_data;
                end else if (pf_grant) begin
                    mem_command_d  = 2'd1;
                    mem_address_d  = pf_address & ~ADDR_W'(1);
                    mem_byte_en_d  = 2'b11;
                    mem_data_out_d = 16'h0000;
                end
            end
            S_EU_B0: begin
                if (mem_ready) begin
                    mem_command_d = 2'd0;
                    if (eu_split) begin
                        lo_byte_d = mem_data_in[15:8];
                    end else begin
                        eu_done_d = 1'b1;
                        if (eu_is_read) begin
                            eu_data_in_d = b0_read_data;
                        end
                    end
                end
            end
            S_EU_B1: begin
                if (mem_command == 2'd0) begin
                    mem_command_d  = eu_command;
                    mem_address_d  = eu_next_word_addr;
                    mem_byte_en_d  = 2'b01;
                    mem_data_out_d = {8'h00, eu_data_out[15:8]};
                end else if (mem_ready) begin
                    mem_command_d = 2'd0;
                    eu_done_d     = 1'b1;
                    if (eu_is_read) begin
                        eu_data_in_d = {mem_data_in[7:0], lo_byte_q};
                    end
                end
            end
            S_PF_RD: begin
                flush_d = flush_now;
                if (mem_ready) begin
                    mem_command_d = 2'd0;
                    // A flush in the completing cycle still suppresses the result
                    if (!flush_now) begin
                        pf_done_d = 1'b1;
                        pf_data_d = mem_data_in;
                    end
                end
            end
            S_DONE: begin
                flush_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_command  <= 2'd0;
            mem_address  <= '0;
            mem_byte_en  <= 2'b00;
            mem_data_out <= 16'h0000;
            eu_data_in   <= 16'h0000;
            eu_done      <= 1'b0;
            pf_data      <= 16'h0000;
            pf_done      <= 1'b0;
            lo_byte_q    <= 8'h00;
            flush_q      <= 1'b0;
            starve_q     <= '0;
        end else begin
            mem_command  <= mem_command_d;
            mem_address  <= mem_address_d;
            mem_byte_en  <= mem_byte_en_d;
            mem_data_out <= mem_data_out_d;
            eu_data_in   <= eu_data_in_d;
            eu_done      <= eu_done_d;
            pf_data      <= pf_data_d;
            pf_done      <= pf_done_d;
            lo_byte_q    <= lo_byte_d;
            flush_q      <= flush_d;
            starve_q     <= starve_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: lane steering, split-word wrap, priority,
// starvation guard, prefetch flush and mid-transaction reset.
module tb_bus_arbiter;

    localparam int unsigned ADDR_W = 20;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        eu_command;
    logic              eu_word;
    logic [ADDR_W-1:0] eu_address;
    logic [15:0]       eu_data_out;
    logic [15:0]       eu_data_in;
    logic              eu_done;
    logic              pf_req;
    logic [ADDR_W-1:0] pf_address;
    logic              pf_flush;
    logic [15:0]       pf_data;
    logic              pf_done;
    logic [1:0]        mem_command;
    logic [ADDR_W-1:0] mem_address;
    logic [1:0]        mem_byte_en;
    logic [15:0]       mem_data_out;
    logic [15:0]       mem_data_in;
    logic              mem_ready;

    int vectors     = 0;
    int miscompares = 0;
    int eu_done_cnt = 0;
    int pf_done_cnt = 0;

    bus_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .eu_command   (eu_command),
        .eu_word      (eu_word),
        .eu_address   (eu_address),
        .eu_data_out  (eu_data_out),
        .eu_data_in   (eu_data_in),
        .eu_done      (eu_done),
        .pf_req       (pf_req),
        .pf_address   (pf_address),
        .pf_flush     (pf_flush),
        .pf_data      (pf_data),
        .pf_done      (pf_done),
        .mem_command  (mem_command),
        .mem_address  (mem_address),
        .mem_byte_en  (mem_byte_en),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    // Done-pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (eu_done === 1'b1) eu_done_cnt++;
        if (pf_done === 1'b1) pf_done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until a bus beat is presented, bounded
    task automatic wait_cmd(input string tag);
        int n = 0;
        step();
        while (mem_command == 2'd0 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (mem_command === 2'd0) begin
            miscompares++;
            $display("FAIL %s_wait_cmd: no bus command within 20 cycles", tag);
        end
    endtask

    task automatic complete(input logic [15:0] rdata);
        mem_data_in = rdata;
        mem_ready   = 1'b1;
        step();
        mem_ready   = 1'b0;
        mem_data_in = 16'h0000;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        eu_command = 2'd0; eu_word = 1'b0; eu_address = '0; eu_data_out = 16'h0;
        pf_req = 1'b0; pf_address = '0; pf_flush = 1'b0;
        mem_data_in = 16'h0; mem_ready = 1'b0;
        step(); step();
        vectors++;
        if ({mem_command, mem_address, mem_byte_en, mem_data_out, eu_data_in, eu_done, pf_data, pf_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: cmd=%0d addr=%h be=%b wd=%h eud=%h eudone=%b pfd=%h pfdone=%b, required all zero",
                     mem_command, mem_address, mem_byte_en, mem_data_out, eu_data_in, eu_done, pf_data, pf_done);
        end
        reset_n = 1'b1;
        step();
        vectors++;
        if (mem_command !== 2'd0) begin
            miscompares++;
            $display("FAIL idle_no_req: mem_command=%0d, required 0", mem_command);
        end
    endtask

    task automatic test_byte_read();
        eu_command = 2'd1; eu_word = 1'b0; eu_address = 20'h12345;
        wait_cmd("byte_read");
        vectors++;
        if (mem_command !== 2'd1 || mem_address !== 20'h12344 || mem_byte_en !== 2'b10) begin
            miscompares++;
            $display("FAIL byte_read_beat: cmd=%0d addr=%h be=%b, required 1 12344 10", mem_command, mem_address, mem_byte_en);
        end
        complete(16'hAB00);
        vectors++;
        if (eu_done !== 1'b1 || eu_data_in !== 16'h00AB) begin
            miscompares++;
            $display("FAIL byte_read_data: done=%b data=%h, required 1 00ab", eu_done, eu_data_in);
        end
        eu_command = 2'd0;
        step();
        vectors++;
        if (eu_done !== 1'b0) begin
            miscompares++;
            $display("FAIL byte_read_pulse: eu_done=%b, required 0", eu_done);
        end
    endtask

    task automatic test_word_write_wrap();
        int c0 = eu_done_cnt;
        eu_command = 2'd2; eu_word = 1'b1; eu_address = 20'hFFFFF; eu_data_out = 16'hBEEF;
        wait_cmd("wrap_b0");
        vectors++;
        if (mem_command !== 2'd2 || mem_address !== 20'hFFFFE || mem_byte_en !== 2'b10 || mem_data_out[15:8] !== 8'hEF) begin
            miscompares++;
            $display("FAIL wrap_beat1: cmd=%0d addr=%h be=%b data=%h, required 2 ffffe 10 ef..", mem_command, mem_address, mem_byte_en, mem_data_out);
        end
        complete(16'h0000);
        vectors++;
        if (mem_command !== 2'd0 || eu_done !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_gap: cmd=%0d done=%b, required 0 0", mem_command, eu_done);
        end
        wait_cmd("wrap_b1");
        vectors++;
        if (mem_command !== 2'd2 || mem_address !== 20'h00000 || mem_byte_en !== 2'b01 || mem_data_out[7:0] !== 8'hBE) begin
            miscompares++;
            $display("FAIL wrap_beat2: cmd=%0d addr=%h be=%b data=%h, required 2 00000 01 ..be", mem_command, mem_address, mem_byte_en, mem_data_out);
        end
        complete(16'h0000);
        eu_command = 2'd0;
        step(); step(); step();
        vectors++;
        if (eu_done_cnt - c0 !== 1) begin
            miscompares++;
            $display("FAIL wrap_done_count: pulses=%0d, required 1", eu_done_cnt - c0);
        end
    endtask

    task automatic test_word_read_split();
        eu_command = 2'd1; eu_word = 1'b1; eu_address = 20'h00101;
        wait_cmd("split_b0");
        complete(16'h3400);
        wait_cmd("split_b1");
        vectors++;
        if (mem_address !== 20'h00102 || mem_byte_en !== 2'b01) begin
            miscompares++;
            $display("FAIL split_beat2: addr=%h be=%b, required 00102 01", mem_address, mem_byte_en);
        end
        complete(16'h0012);
        vectors++;
        if (eu_done !== 1'b1 || eu_data_in !== 16'h1234) begin
            miscompares++;
            $display("FAIL split_read_data: done=%b data=%h, required 1 1234", eu_done, eu_data_in);
        end
        eu_command = 2'd0;
        step();
    endtask

    task automatic test_eu_pf_priority();
        int p0 = pf_done_cnt;
        eu_command = 2'd1; eu_word = 1'b1; eu_address = 20'h00200;
        pf_req = 1'b1; pf_address = 20'h00401;
        wait_cmd("prio_eu");
        vectors++;
        if (mem_address !== 20'h00200 || mem_byte_en !== 2'b11) begin
            miscompares++;
            $display("FAIL prio_eu_first: addr=%h be=%b, required 00200 11", mem_address, mem_byte_en);
        end
        complete(16'h5555);
        vectors++;
        if (eu_done !== 1'b1 || eu_data_in !== 16'h5555) begin
            miscompares++;
            $display("FAIL prio_eu_data: done=%b data=%h, required 1 5555", eu_done, eu_data_in);
        end
        eu_command = 2'd0;
        wait_cmd("prio_pf");
        vectors++;
        if (mem_address !== 20'h00400 || mem_byte_en !== 2'b11 || pf_done_cnt !== p0) begin
            miscompares++;
            $display("FAIL prio_pf_second: addr=%h be=%b early_pf_done=%0d, required 00400 11 0", mem_address, mem_byte_en, pf_done_cnt - p0);
        end
        complete(16'hCAFE);
        vectors++;
        if (pf_done !== 1'b1 || pf_data !== 16'hCAFE) begin
            miscompares++;
            $display("FAIL prio_pf_data: done=%b data=%h, required 1 cafe", pf_done, pf_data);
        end
        pf_req = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        logic [9:0] seen;
        logic [9:0] expect_pf;
        expect_pf = 10'b10000_10000;
        seen = '0;
        eu_command = 2'd1; eu_word = 1'b0; eu_address = 20'h00010;
        pf_req = 1'b1; pf_address = 20'h00800;
        for (int g = 0; g < 10; g++) begin
            wait_cmd("starve");
            seen[g] = (mem_address == 20'h00800);
            complete(16'h0000);
        end
        vectors++;
        if (seen !== expect_pf) begin
            miscompares++;
            $display("FAIL starve_pattern: grants(bit=pf,lsb first)=%b, required %b", seen, expect_pf);
        end
        eu_command = 2'd0; pf_req = 1'b0;
        step(); step();
    endtask

    task automatic test_flush();
        int p0 = pf_done_cnt;
        pf_req = 1'b1; pf_address = 20'h00900;
        wait_cmd("flush");
        pf_flush = 1'b1;
        step();
        pf_flush = 1'b0; pf_req = 1'b0;
        step(); step();
        vectors++;
        if (mem_command !== 2'd1 || mem_address !== 20'h00900) begin
            miscompares++;
            $display("FAIL flush_hold: cmd=%0d addr=%h, required 1 00900", mem_command, mem_address);
        end
        complete(16'h1111);
        vectors++;
        if (mem_command !== 2'd0 || pf_done !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_complete: cmd=%0d pf_done=%b, required 0 0", mem_command, pf_done);
        end
        step(); step(); step();
        vectors++;
        if (pf_done_cnt !== p0) begin
            miscompares++;
            $display("FAIL flush_no_done: pulses=%0d, required 0", pf_done_cnt - p0);
        end
    endtask

    task automatic test_reset_mid_txn();
        int c0;
        eu_command = 2'd1; eu_word = 1'b1; eu_address = 20'h00301;
        wait_cmd("rst_b0");
        complete(16'h7700);
        wait_cmd("rst_b1");
        vectors++;
        if (mem_address !== 20'h00302 || mem_byte_en !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_in_b1: addr=%h be=%b, required 00302 01", mem_address, mem_byte_en);
        end
        c0 = eu_done_cnt;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({mem_command, mem_address, mem_byte_en, mem_data_out, eu_data_in, eu_done, pf_data, pf_done} !== '0) begin
            miscompares++;
            $display("FAIL rst_async_clear: cmd=%0d addr=%h be=%b wd=%h eud=%h pfd=%h, required all zero",
                     mem_command, mem_address, mem_byte_en, mem_data_out, eu_data_in, pf_data);
        end
        eu_command = 2'd0;
        step(); step();
        reset_n = 1'b1;
        step(); step();
        vectors++;
        if (eu_done_cnt !== c0) begin
            miscompares++;
            $display("FAIL rst_no_done: pulses=%0d, required 0", eu_done_cnt - c0);
        end
        eu_command = 2'd2; eu_word = 1'b0; eu_address = 20'h00021; eu_data_out = 16'h0077;
        wait_cmd("rst_fresh");
        vectors++;
        if (mem_address !== 20'h00020 || mem_byte_en !== 2'b10 || mem_data_out[15:8] !== 8'h77) begin
            miscompares++;
            $display("FAIL rst_fresh_beat: addr=%h be=%b data=%h, required 00020 10 77..", mem_address, mem_byte_en, mem_data_out);
        end
        complete(16'h0000);
        vectors++;
        if (eu_done !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_fresh_done: eu_done=%b, required 1", eu_done);
        end
        eu_command = 2'd0;
        step();
    endtask

    initial begin
        test_reset();
        test_byte_read();
        test_word_write_wrap();
        test_word_read_split();
        test_eu_pf_priority();
        test_starvation();
        test_flush();
        test_reset_mid_txn();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
